// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-back arbiter and pending-write scoreboard for the integer register file.
// NUM_SRC producers request the single register-file write port. One request
// is granted per cycle, with round-robin priority. The winner is registered
// into a write stage that drives the register file. A per-register busy bit
// tracks results that have issued but are not yet written back, so issue logic
// can detect read-after-write hazards.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   req_valid    [NUM_SRC]              per-source write request valid
//   req_ready    [NUM_SRC]              one-hot grant (combinational from req_valid)
//   req_rd       [NUM_SRC*ADDR_WIDTH]   packed destination registers
//   req_data     [NUM_SRC*DATA_WIDTH]   packed write data
//   issue_valid  1                      an instruction writing issue_rd issued
//   issue_rd     [ADDR_WIDTH]           destination of the issued instruction
//   rf_we        1                      register file RegWrite
//   rf_rd        [ADDR_WIDTH]           register file rd
//   rf_wdata     [DATA_WIDTH]           register file write_data
//   grant_id     [$clog2(NUM_SRC)]      source of the current rf_* write
//   busy         [NUM_REGS]             bit r set while register r is pending
// -----------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 32,
    parameter int NUM_SRC    = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SRC-1:0]             req_valid,
    output logic [NUM_SRC-1:0]             req_ready,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0]  req_rd,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]  req_data,
    input  logic                           issue_valid,
    input  logic [ADDR_WIDTH-1:0]          issue_rd,
    output logic                           rf_we,
    output logic [ADDR_WIDTH-1:0]          rf_rd,
    output logic [DATA_WIDTH-1:0]          rf_wdata,
    output logic [$clog2(NUM_SRC)-1:0]     grant_id,
    output logic [NUM_REGS-1:0]            busy
);

    localparam int SRC_W = $clog2(NUM_SRC);

    // Round-robin pointer: the source that currently has the highest priority.
    logic [SRC_W-1:0]      ptr;

    logic                  gnt_found;
    logic [SRC_W-1:0]      gnt_idx;
    logic                  transfer;
    logic [ADDR_WIDTH-1:0] sel_rd;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [NUM_REGS-1:0]   busy_next;
    int                    cand;

    // -------------------------------------------------------------------------
    // Arbitration: search from ptr upward and wrap modulo NUM_SRC. The wrap is
    // an explicit subtract, so NUM_SRC does not have to be a power of two.
    // -------------------------------------------------------------------------
    // NOTE: every variable assigned in an always_comb gets a default value
    // first. Otherwise a path that skips the assignment infers a latch.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = int'(ptr) + k;
            if (cand >= NUM_SRC)
                cand = cand - NUM_SRC;
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = SRC_W'(cand);
            end
        end
    end

    // No grant is accepted while in reset. A request held across reset is
    // therefore discarded and must be re-presented afterwards.
    assign transfer = gnt_found && !reset;

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_SRC; i++)
            req_ready[i] = transfer && (gnt_idx == SRC_W'(i));
    end

    // Select the winning request's payload.
    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                sel_rd   = req_rd[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Pointer update: after a grant to g, priority moves to g+1 (with wrap).
    // The pointer holds its value in idle cycles.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All flops
    // then sample the values from before the edge, whatever order the blocks
    // run in.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (transfer) begin
            if (gnt_idx == SRC_W'(NUM_SRC - 1))
                ptr <= '0;
            else
                ptr <= gnt_idx + SRC_W'(1);
        end
    end

    // -------------------------------------------------------------------------
    // Write stage. An rd==0 request is consumed but does not raise rf_we.
    // The payload registers hold their value when there is no transfer.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            grant_id <= '0;
        end else begin
            rf_we <= transfer && (sel_rd != '0);
            if (transfer) begin
                rf_rd    <= sel_rd;
                rf_wdata <= sel_data;
                grant_id <= gnt_idx;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard. The clear is applied first and the set second, so a new
    // producer issued in the same edge as a write-back to the same register
    // leaves that register busy. busy[0] is forced to zero.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_next = busy;
        if (transfer && (sel_rd != '0))
            busy_next[sel_rd] = 1'b0;
        if (issue_valid && (issue_rd != '0))
            busy_next[issue_rd] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // NOTE: busy is a flop vector, not a RAM. Resetting all of it costs
    // nothing and gives issue logic a known-clean scoreboard after reset.
    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;
    localparam int NR = 32;
    localparam int NS = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NS-1:0]   req_valid;
    logic [NS-1:0]   req_ready;
    logic [NS*AW-1:0] req_rd;
    logic [NS*DW-1:0] req_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic            rf_we;
    logic [AW-1:0]   rf_rd;
    logic [DW-1:0]   rf_wdata;
    logic [0:0]      grant_id;
    logic [NR-1:0]   busy;

    int n_vec = 0;
    int n_bad = 0;

    regfile_wb_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .NUM_SRC(NS)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_data(req_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and stop 1 ns after it, clear of the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [AW-1:0] rd, input logic [DW-1:0] d);
        req_rd[s*AW +: AW]   = rd;
        req_data[s*DW +: DW] = d;
    endtask

    initial begin
        logic [0:0] exp_g [4];
        exp_g[0] = 1'b0; exp_g[1] = 1'b1; exp_g[2] = 1'b0; exp_g[3] = 1'b1;

        reset       = 1'b1;
        req_valid   = 2'b11;
        req_rd      = '0;
        req_data    = '0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        set_src(0, 5'd1, 64'h1);
        set_src(1, 5'd2, 64'h2);

        // Reset held for 2 cycles while both sources request.
        #1;
        check("rst_ready", req_ready, 2'b00);
        step();
        check("rst_ready2", req_ready, 2'b00);
        step();
        check("rst_we", rf_we, 0);
        check("rst_busy", busy, 0);
        check("rst_ptr", dut.ptr, 0);
        check("rst_rd", rf_rd, 0);
        req_valid = 2'b00;
        reset     = 1'b0;
        step();
        check("idle_we", rf_we, 0);
        check("idle_ptr", dut.ptr, 0);

        // Single source 1.
        set_src(1, 5'd5, 64'hDEAD_BEEF_0000_0001);
        req_valid = 2'b10;
        #1;
        check("single_ready", req_ready, 2'b10);
        step();
        req_valid = 2'b00;
        check("single_we", rf_we, 1);
        check("single_rd", rf_rd, 5);
        check("single_data", rf_wdata, 64'hDEAD_BEEF_0000_0001);
        check("single_gid", grant_id, 1);

        // Contention: ptr is 0 again, so the grants go 0,1,0,1.
        set_src(0, 5'd10, 64'hA0);
        set_src(1, 5'd11, 64'hB1);
        req_valid = 2'b11;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("cont_ready%0d", c), req_ready, (exp_g[c] == 1'b0) ? 2'b01 : 2'b10);
            step();
            check($sformatf("cont_we%0d", c), rf_we, 1);
            check($sformatf("cont_gid%0d", c), grant_id, exp_g[c]);
            check($sformatf("cont_rd%0d", c), rf_rd, (exp_g[c] == 1'b0) ? 10 : 11);
        end
        req_valid = 2'b00;
        step();
        check("cont_idle_we", rf_we, 0);
        check("cont_hold_rd", rf_rd, 11);
        check("cont_hold_gid", grant_id, 1);

        // Scoreboard: issue rd=7.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        issue_valid = 1'b0;
        check("sb_set7", busy, 32'h0000_0080);

        // rd=0 request from source 0: consumed, no write, busy unchanged.
        set_src(0, 5'd0, 64'hFFFF);
        req_valid = 2'b01;
        #1;
        check("rd0_ready", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("rd0_we", rf_we, 0);
        check("rd0_data", rf_wdata, 64'hFFFF);
        check("rd0_busy", busy, 32'h0000_0080);
        check("rd0_ptr", dut.ptr, 1);

        // Write-back of rd=7 from source 1 clears busy[7] while rf_we is high.
        set_src(1, 5'd7, 64'h77);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        check("wb7_we", rf_we, 1);
        check("wb7_busy", busy, 0);

        // Same-edge issue and write-back of rd=7: the set wins.
        issue_valid = 1'b1;
        issue_rd    = 5'd7;
        step();
        check("sb_reset7", busy, 32'h0000_0080);
        set_src(0, 5'd7, 64'h7777);
        req_valid = 2'b01;
        step();
        req_valid   = 2'b00;
        issue_valid = 1'b0;
        check("same_we", rf_we, 1);
        check("same_busy", busy, 32'h0000_0080);

        // Clearing a register that is not busy leaves it 0.
        set_src(1, 5'd12, 64'hC);
        req_valid = 2'b10;
        step();
        req_valid = 2'b00;
        check("clr_idle_busy", busy, 32'h0000_0080);

        // Issue to rd=0 never sets busy[0].
        issue_valid = 1'b1;
        issue_rd    = 5'd0;
        step();
        check("busy0", busy, 32'h0000_0080);

        // Mid-operation reset: issue 3 and 9, then source 0 holds rd=3.
        issue_rd = 5'd3;
        step();
        issue_rd = 5'd9;
        step();
        issue_valid = 1'b0;
        check("mid_busy_pre", busy, 32'h0000_0288);
        set_src(0, 5'd3, 64'h3333);
        req_valid = 2'b01;
        reset     = 1'b1;
        #1;
        check("mid_ready_rst", req_ready, 2'b00);
        step();
        check("mid_busy", busy, 0);
        check("mid_we", rf_we, 0);
        check("mid_ptr", dut.ptr, 0);
        reset = 1'b0;
        #1;
        check("mid_ready_rel", req_ready, 2'b01);
        step();
        req_valid = 2'b00;
        check("mid_we2", rf_we, 1);
        check("mid_rd", rf_rd, 3);
        check("mid_gid", grant_id, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 64-bit, 32-entry integer register file. It takes write requests from `NUM_SRC` producers (ALU, load unit, and others) and grants one per cycle with round-robin priority. The winning request drives the register file's single write port (`RegWrite` / `rd` / `write_data`) through a registered stage. It also keeps a per-register busy bit so issue logic can detect read-after-write hazards.

## Interface
- `DATA_WIDTH`, 64, write data width.
- `ADDR_WIDTH`, 5, register address width.
- `NUM_REGS`, 32, number of architectural registers (2^ADDR_WIDTH).
- `NUM_SRC`, 2, number of write-back requesters (2..8).
- `clk`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_SRC  per-source write request valid.
- `req_ready`  out  NUM_SRC  per-source grant; transfer occurs when `req_valid[i] && req_ready[i]`.
- `req_rd`  in  NUM_SRC*ADDR_WIDTH  packed destination addresses; source i is at bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_data`  in  NUM_SRC*DATA_WIDTH  packed write data; source i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `issue_valid`  in  1  an instruction writing `issue_rd` has issued.
- `issue_rd`  in  ADDR_WIDTH  destination register of the issued instruction.
- `rf_we`  out  1  to register file `RegWrite`.
- `rf_rd`  out  ADDR_WIDTH  to register file `rd`.
- `rf_wdata`  out  DATA_WIDTH  to register file `write_data`.
- `grant_id`  out  $clog2(NUM_SRC)  source index of the current `rf_*` write (debug).
- `busy`  out  NUM_REGS  bit r = 1 when register r has a pending, unwritten result.

## Operation
**Arbitration**
- Round-robin pointer `ptr` holds the highest-priority source.
- The grant goes to the first asserted `req_valid` found by searching from `ptr` upward, wrapping modulo NUM_SRC.
- `req_ready` is combinational and one-hot: it is asserted only for the granted source, and is all-zero when no source is valid.
- The write port is never back-pressured, so exactly one transfer happens every cycle in which any source is valid.
- After a transfer from source g, `ptr` becomes (g+1) mod NUM_SRC. `ptr` is unchanged in idle cycles.

**Source protocol**
- Once a source asserts `req_valid`, it holds `req_valid`, `req_rd` and `req_data` stable until the transfer completes.
- `req_valid` must not depend on `req_ready`.

**Write stage**
- On a transfer, the next edge registers the request into the write stage:
  - `rf_rd` ← `req_rd[g]`
  - `rf_wdata` ← `req_data[g]`
  - `grant_id` ← g
  - `rf_we` ← 1 if `req_rd[g] != 0`, else 0.
- A request with rd == 0 is accepted and consumed, but produces no write.
- With no transfer, `rf_we` ← 0. `rf_rd`, `rf_wdata` and `grant_id` hold their previous values.

**Scoreboard**
- At each edge:
  - If `issue_valid && issue_rd != 0`, set `busy[issue_rd]`.
  - If a transfer with rd != 0 occurred, clear `busy[rd]`.
- If the set and the clear target the same register in the same edge, set wins: the new producer is still outstanding.
- `busy[0]` is constantly 0.
- Clearing a register that is not busy is legal and leaves it 0.

**Reset**
- `ptr` = 0, `rf_we` = 0, `rf_rd` = 0, `rf_wdata` = 0, `grant_id` = 0, `busy` = 0.
- While `reset` is high, `req_ready` = 0, so no transfer is accepted during a reset cycle.
- A request in flight when reset asserts is discarded. Its source must re-present it after reset.

## Timing
- Request to write port: the transfer at edge N gives `rf_we` = 1 during cycle N+1, and the register file captures the data at edge N+1.
- The `busy` clear is visible in the cycle after the transfer edge, the same cycle `rf_we` is high.
- Issue logic must therefore still forward from `rf_wdata` when `rf_we && rf_rd == src`.
- Throughput: one write per cycle, back-to-back, with no bubble between grants to different sources.
- Fairness: a continuously valid source is granted within NUM_SRC cycles.
- The `req_valid` → `req_ready` path is combinational. There is no combinational path from `req_*` to `rf_*` or `busy`.

## Test plan
- **Reset:** drive `reset` = 1 for 2 cycles with `req_valid` = 2'b11 → `req_ready` = 0, `rf_we` = 0, `busy` = 0, `ptr` = 0 after release.
- **Single source:** source 1 requests rd = 5, data = 64'hDEAD_BEEF_0000_0001 → `req_ready` = 2'b10 the same cycle. Next cycle: `rf_we` = 1, `rf_rd` = 5, `rf_wdata` = 64'hDEAD_BEEF_0000_0001, `grant_id` = 1.
- **Contention:** both sources valid for 4 cycles with distinct rd → grants alternate 0, 1, 0, 1 and `rf_we` stays high for 4 consecutive cycles.
- **rd = 0:** source 0 requests rd = 0, data = 64'hFFFF → the request is accepted (`req_ready[0]` = 1), `rf_we` = 0 next cycle, and `busy` is unchanged.
- **Scoreboard:**
  - Issue rd = 7 → `busy[7]` = 1. A later write-back of rd = 7 → `busy[7]` = 0 in the cycle `rf_we` = 1.
  - Issue rd = 7 in the same edge as a write-back of rd = 7 → `busy[7]` stays 1.
- **Mid-operation reset:** source 0 is valid, holding rd = 3 after issuing rd = 3 and rd = 9. Assert `reset` for 1 cycle → `busy` = 0, `rf_we` = 0 and `ptr` = 0. After release, the held request is granted and `rf_rd` = 3 one cycle later.
